binary_run_extractor: RTL and testbench
=======================================

BINARY_RUN_EXTRACTOR -- requirements
Module: binary_run_extractor

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter XW, default 11: width of column, line and length fields.
REQ-003 SHALL have parameter MIN_RUN, default 4: minimum white-run length that is reported.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two: number of record slots.
REQ-005 SHALL have port clk, input, 1: pixel clock.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port in_vsync, input, 1: frame sync from the binarizer, rising edge = new frame.
REQ-008 SHALL have port in_hsync, input, 1: line sync, pass-through timing only and not used for counting.
REQ-009 SHALL have port in_de, input, 1: pixel valid.
REQ-010 SHALL have port in_monoc, input, 1: binarized pixel, 1 = white.
REQ-011 SHALL have port rec_valid, output, 1: a record is available.
REQ-012 SHALL have port rec_ready, input, 1: consumer accepts the record.
REQ-013 SHALL have ports rec_line, rec_start and rec_len, output, XW each: line index, first column and length of the longest white run.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at each new frame.
REQ-015 SHALL have port overflow, output, 1: sticky flag set when a record is dropped.

Function
REQ-016 SHALL count column x from 0: increment on each in_de=1 cycle; clear on the first in_de=0 cycle after a line (end-of-line, EOL).
REQ-017 SHALL increment line y at each EOL, saturating at 2^XW-1.
REQ-018 SHALL clear y on the in_vsync rising edge, detected against a registered copy of in_vsync.
REQ-019 SHALL implement a per-line FSM with states IDLE and RUN.
- IDLE -> RUN on in_de & in_monoc; cur_start = x, cur_len = 1.
- RUN, in_de & in_monoc: cur_len increments, saturating.
- RUN -> IDLE on in_de & !in_monoc, or on EOL: run closed.
REQ-020 SHALL, on each run close, replace the stored best run when cur_len > best_len. Ties keep the earlier run.
REQ-021 SHALL include a run closed by EOL in that same line's EOL evaluation.
REQ-022 SHALL, at EOL, push {y, best_start, best_len} when best_len >= MIN_RUN, then clear the best run. Lines with no qualifying run push nothing.
REQ-023 SHALL assert rec_valid in the cycle after the EOL cycle when the FIFO was previously empty. Latency from EOL to rec_valid is 1 cycle.
REQ-024 SHALL use valid/ready handshaking: a transfer occurs when rec_valid & rec_ready. The rec_* fields SHALL hold stable while rec_valid & !rec_ready.
REQ-025 SHALL, when the FIFO is full at push time with no pop, drop the record and set overflow.
REQ-026 SHALL accept a push that coincides with a pop while full.
REQ-027 SHALL pulse frame_done for one cycle on the in_vsync rising edge.
REQ-028 SHALL, on the in_vsync rising edge, clear overflow, abort any in-progress run without a push, clear the best run, and force IDLE.
REQ-029 SHALL NOT flush FIFO contents on the in_vsync rising edge.
REQ-030 SHALL give vsync precedence over EOL when both occur in the same cycle: no push for that line.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, set:
- rec_valid=0, frame_done=0, overflow=0;
- rec_line, rec_start and rec_len to 0;
- FIFO empty, FSM in IDLE;
- x, y and best state to 0.
REQ-032 SHALL discard any in-progress line or pending records on reset asserted mid-operation. The first EOL after reset release evaluates only pixels seen after release.

Configuration
REQ-033 SHALL, when macro RUN_SUM_EN is defined, add output rec_sum, XW+1 bits, holding the total white-pixel count of the line, saturating. It is carried in the FIFO alongside each record.
REQ-034 SHALL, when RUN_SUM_EN is undefined, have no rec_sum port and no sum storage. All other behaviour is identical.

Verification
REQ-035 SHALL cover: line of 20 pixels, white at x=5..12, rec_ready=1 -> one record {line 0, start 5, len 8}, rec_valid 1 cycle after EOL.
REQ-036 SHALL cover: runs x=2..5 and x=10..13 on one line -> start 2, len 4 (tie keeps earlier).
REQ-037 SHALL cover: white at x=16..19 ending at the last de pixel -> start 16, len 4. Run x=0..2 only -> no record (MIN_RUN=4).
REQ-038 SHALL cover: rec_ready=0, 9 qualifying lines -> 8 records held, overflow=1, records read in line order 0..7, overflow cleared at next vsync rise with frame_done pulse.
REQ-039 SHALL cover: vsync rise mid-run -> no record for that line, next frame's first record has line 0.
REQ-040 SHALL cover: with RUN_SUM_EN, line with 3+6 white pixels -> rec_sum=9.

Source files
------------

// File: rtl/binary_run_extractor_if.sv
// Record stream from binary_run_extractor to its consumer (line, start, length [, sum]).
// Latency: none, plain wires bundled for port grouping.
// Backpressure: valid/ready; fields hold while rec_valid & !rec_ready. rec_sum exists only with RUN_SUM_EN.
interface binary_run_extractor_if #(
  parameter int XW = 11
);
  logic          rec_valid;
  logic          rec_ready;
  logic [XW-1:0] rec_line;
  logic [XW-1:0] rec_start;
  logic [XW-1:0] rec_len;
`ifdef RUN_SUM_EN
  logic [XW:0]   rec_sum;

  modport master (output rec_valid, rec_line, rec_start, rec_len, rec_sum, input rec_ready);
  modport slave  (input rec_valid, rec_line, rec_start, rec_len, rec_sum, output rec_ready);
`else
  modport master (output rec_valid, rec_line, rec_start, rec_len, input rec_ready);
  modport slave  (input rec_valid, rec_line, rec_start, rec_len, output rec_ready);
`endif
endinterface

// File: rtl/binary_run_extractor.sv
// Finds the longest white run of each binarized line and queues {line, start, len} records.
// Latency: record visible on rec_valid one cycle after the end-of-line cycle (FIFO previously empty).
// Backpressure: FIFO_DEPTH-entry record FIFO; push while full without pop drops and sets overflow.
// Optional macro RUN_SUM_EN adds rec_sum (white pixels per line) carried with each record.
module binary_run_extractor #(
  parameter int XW         = 11,
  parameter int MIN_RUN    = 4,
  parameter int FIFO_DEPTH = 8   // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vsync,
  input  logic                   in_hsync,
  input  logic                   in_de,
  input  logic                   in_monoc,
  binary_run_extractor_if.master rec,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int            AW   = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0] XMAX = '1;
`ifdef RUN_SUM_EN
  localparam logic [XW:0]   SMAX = '1;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
`ifdef RUN_SUM_EN
    logic [XW:0]   sum;
`endif
    logic [XW-1:0] line;
    logic [XW-1:0] start;
    logic [XW-1:0] len;
  } rec_t;

  // hsync carries no information the counters need; line ends come from de.
  logic unused_hsync;
  assign unused_hsync = in_hsync;

  logic          vs_q, de_q;
  logic [XW-1:0] x_q, y_q;
  state_t        state_q;
  logic [XW-1:0] cur_start_q, cur_len_q;
  logic [XW-1:0] best_start_q, best_len_q;
`ifdef RUN_SUM_EN
  logic [XW:0]   sum_q;
`endif
  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          frame_done_q, overflow_q;

  logic          vs_rise, eol, pix_w, run_close, take_cur;
  logic [XW-1:0] best_start_d, best_len_d;
  logic          push_req, push, pop, drop, empty, full;
  rec_t          new_rec, rd_rec;

  // Event decode and the best run as it stands including a run closing this cycle.
  always_comb begin
    vs_rise      = in_vsync & ~vs_q;
    eol          = ~in_de & de_q;
    pix_w        = in_de & in_monoc;
    run_close    = (state_q == RUN) & ((in_de & ~in_monoc) | eol);
    take_cur     = run_close & (cur_len_q > best_len_q);   // strict: ties keep earlier run
    best_start_d = take_cur ? cur_start_q : best_start_q;
    best_len_d   = take_cur ? cur_len_q   : best_len_q;
    empty        = (cnt_q == '0);
    full         = (cnt_q == (AW+1)'(FIFO_DEPTH));
    pop          = ~empty & rec.rec_ready;
    // vsync wins over a coincident EOL: that line is abandoned.
    push_req     = eol & ~vs_rise & (best_len_d >= XW'(MIN_RUN));
    push         = push_req & (~full | pop);
    drop         = push_req & full & ~pop;
    new_rec       = '0;
    new_rec.line  = y_q;
    new_rec.start = best_start_d;
    new_rec.len   = best_len_d;
`ifdef RUN_SUM_EN
    new_rec.sum   = sum_q;
`endif
  end

  // Column/line counters and sync history. A vsync rise also forgets the current
  // line so a partial line at frame start never produces an EOL.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= in_vsync;
      if (vs_rise) begin
        de_q <= 1'b0;
        x_q  <= '0;
        y_q  <= '0;
      end else begin
        de_q <= in_de;
        if (in_de) begin
          if (x_q != XMAX) x_q <= x_q + XW'(1);
        end else if (eol) begin
          x_q <= '0;
        end
        if (eol && (y_q != XMAX)) y_q <= y_q + XW'(1);
      end
    end
  end

  // Per-line run FSM with current and best run tracking.
  always_ff @(posedge clk) begin
    if (rst || vs_rise) begin
      state_q      <= IDLE;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      if (eol) begin
        best_start_q <= '0;
        best_len_q   <= '0;
      end else if (take_cur) begin
        best_start_q <= cur_start_q;
        best_len_q   <= cur_len_q;
      end
      case (state_q)
        IDLE: begin
          if (pix_w) begin
            state_q     <= RUN;
            cur_start_q <= x_q;
            cur_len_q   <= XW'(1);
          end
        end
        RUN: begin
          if (eol || (in_de && !in_monoc)) begin
            state_q <= IDLE;
          end else if (pix_w && (cur_len_q != XMAX)) begin
            cur_len_q <= cur_len_q + XW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RUN_SUM_EN
  // Saturating count of white pixels in the current line.
  always_ff @(posedge clk) begin
    if (rst || vs_rise || eol) begin
      sum_q <= '0;
    end else if (pix_w && (sum_q != SMAX)) begin
      sum_q <= sum_q + (XW+1)'(1);
    end
  end
`endif

  // Record storage; pointers alone define occupancy so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  // FIFO pointers, frame pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= vs_rise;
      if (vs_rise)   overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign rd_rec        = mem_q[rd_ptr_q];
  assign rec.rec_valid = ~empty;
  assign rec.rec_line  = empty ? '0 : rd_rec.line;
  assign rec.rec_start = empty ? '0 : rd_rec.start;
  assign rec.rec_len   = empty ? '0 : rd_rec.len;
`ifdef RUN_SUM_EN
  assign rec.rec_sum   = empty ? '0 : rd_rec.sum;
`endif
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_binary_run_extractor.sv
// Self-checking bench for binary_run_extractor: vector table, corner sequences, random frames.
// Every cycle outputs are compared with a line-buffer reference model and a record queue.
// Runs with the default build or with RUN_SUM_EN defined.
module tb_binary_run_extractor;
  localparam int XW = 11, MIN_RUN = 4, DEPTH = 8;
  localparam int YMAX = (1 << XW) - 1;
  localparam int SMAX = (1 << (XW + 1)) - 1;

  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, hs = 1'b0, de = 1'b0, mono = 1'b0;
  logic frame_done, overflow;
  always #5 clk = ~clk;

  binary_run_extractor_if #(.XW(XW)) rif ();

  binary_run_extractor #(.XW(XW), .MIN_RUN(MIN_RUN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vsync(vs), .in_hsync(hs), .in_de(de), .in_monoc(mono),
    .rec(rif), .frame_done(frame_done), .overflow(overflow));

  int n_checks = 0, n_errors = 0;
  bit rand_ready = 0;

  typedef struct { int line; int start; int len; int sum; } mrec_t;
  mrec_t mq[$];
  bit    line_q[$];
  bit    m_vs_prev = 0, m_de_prev = 0, m_fd = 0, m_ovf = 0;
  int    m_y = 0;

  typedef struct { logic [31:0] mask; int width; bit exp_vld; int exp_start; int exp_len; } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: buffer the line, find the first longest run of ones at line end.
  task automatic model_step();
    bit vs_rise, pop, push;
    mrec_t r;
    int run, rs;
    if (rst) begin
      mq.delete(); line_q.delete();
      m_vs_prev = 0; m_de_prev = 0; m_fd = 0; m_ovf = 0; m_y = 0;
      return;
    end
    vs_rise = vs && !m_vs_prev;
    m_vs_prev = vs;
    m_fd = vs_rise;
    pop = (mq.size() > 0) && rif.rec_ready;
    push = 0;
    r = '{0, 0, 0, 0};
    if (vs_rise) begin
      line_q.delete(); m_y = 0; m_ovf = 0; m_de_prev = 0;
    end else begin
      if (de) line_q.push_back(mono);
      else if (m_de_prev) begin
        run = 0; rs = 0;
        foreach (line_q[i]) begin
          if (line_q[i]) begin
            if (run == 0) rs = i;
            run++;
            if (run > r.len) begin r.len = run; r.start = rs; end
            if (r.sum < SMAX) r.sum++;
          end else run = 0;
        end
        r.line = m_y;
        push = (r.len >= MIN_RUN);
        line_q.delete();
        if (m_y < YMAX) m_y++;
      end
      m_de_prev = de;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("rec_valid", rif.rec_valid, 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("rec_line", rif.rec_line, mq[0].line);
      chk("rec_start", rif.rec_start, mq[0].start);
      chk("rec_len", rif.rec_len, mq[0].len);
`ifdef RUN_SUM_EN
      chk("rec_sum", rif.rec_sum, mq[0].sum);
`endif
    end
    chk("frame_done", frame_done, m_fd);
    chk("overflow", overflow, m_ovf);
    model_step();
    @(posedge clk); #1;
    if (rand_ready) rif.rec_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pix(input bit d, input bit m);
    de = d; mono = m; hs = ~d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(0, 0);
  endtask

  // Pixels of one line followed by the EOL cycle; returns just after the EOL edge.
  task automatic send_line(input logic [31:0] mask, input int width);
    for (int x = 0; x < width; x++) pix(1, mask[x]);
    pix(0, 0);
  endtask

  task automatic vsync_pulse();
    vs = 1; tick();
    chk("frame_done_pulse", frame_done, 1);
    vs = 0; tick();
    chk("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    tv[0] = '{32'h0000_1FE0, 20, 1, 5, 8};   // white 5..12
    tv[1] = '{32'h0000_3C3C, 20, 1, 2, 4};   // 2..5 and 10..13 tie
    tv[2] = '{32'h000F_0000, 20, 1, 16, 4};  // run ends at last de pixel
    tv[3] = '{32'h0000_0007, 20, 0, 0, 0};   // 0..2 too short
    tv[4] = '{32'h000F_FFFF, 20, 1, 0, 20};  // whole line white
    tv[5] = '{32'h0000_F7CE, 16, 1, 6, 5};   // longer later run replaces
    tv[6] = '{32'h0000_0000, 8, 0, 0, 0};    // all black
    tv[7] = '{32'h0000_000F, 20, 1, 0, 4};   // exactly MIN_RUN at column 0

    rif.rec_ready = 1;
    rst = 1;
    tick(); tick();
    chk("rst_rec_valid", rif.rec_valid, 0);
    chk("rst_rec_line", rif.rec_line, 0);
    chk("rst_rec_start", rif.rec_start, 0);
    chk("rst_rec_len", rif.rec_len, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    idle(2);

    // Table of single lines, one record (or none) each, line index = table index.
    vsync_pulse();
    for (int i = 0; i < 8; i++) begin
      for (int x = 0; x < tv[i].width; x++) pix(1, tv[i].mask[x]);
      chk("tv_pre_eol_valid", rif.rec_valid, 0);
      pix(0, 0);
      chk("tv_valid", rif.rec_valid, tv[i].exp_vld);
      if (tv[i].exp_vld) begin
        chk("tv_line", rif.rec_line, i);
        chk("tv_start", rif.rec_start, tv[i].exp_start);
        chk("tv_len", rif.rec_len, tv[i].exp_len);
      end
      idle(2);
    end

`ifdef RUN_SUM_EN
    // 3 + 6 white pixels on line 8.
    send_line(32'h0000_07E7, 20);
    chk("sum_valid", rif.rec_valid, 1);
    chk("sum_start", rif.rec_start, 5);
    chk("sum_len", rif.rec_len, 6);
    chk("sum_total", rif.rec_sum, 9);
    idle(2);
`endif

    // Overflow: nine qualifying lines with the consumer stalled.
    vsync_pulse();
    rif.rec_ready = 0;
    for (int l = 0; l < 9; l++) begin
      send_line(32'h0000_001F, 10);
      idle(1);
    end
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_valid", rif.rec_valid, 1);
      chk("ovf_order", rif.rec_line, k);
      rif.rec_ready = 1; tick(); rif.rec_ready = 0;
    end
    chk("ovf_drained", rif.rec_valid, 0);
    chk("ovf_sticky", overflow, 1);
    vsync_pulse();
    chk("ovf_cleared", overflow, 0);

    // vsync rising in the middle of a run on line 1.
    rif.rec_ready = 1;
    send_line(32'h0000_003C, 10);
    idle(2);
    for (int x = 0; x < 8; x++) pix(1, x >= 3);
    vs = 1; pix(1, 1);
    chk("midrun_frame_done", frame_done, 1);
    pix(0, 0); pix(0, 0);
    chk("midrun_no_record", rif.rec_valid, 0);
    vs = 0; idle(2);
    chk("midrun_still_none", rif.rec_valid, 0);
    send_line(32'h0000_00FC, 10);
    chk("midrun_next_valid", rif.rec_valid, 1);
    chk("midrun_next_line0", rif.rec_line, 0);
    chk("midrun_next_start", rif.rec_start, 2);
    chk("midrun_next_len", rif.rec_len, 6);
    idle(2);

    // Reset in the middle of a line with a record pending.
    rif.rec_ready = 0;
    send_line(32'h0000_001F, 10);
    idle(1);
    chk("mrst_pending", rif.rec_valid, 1);
    pix(1, 1); pix(1, 1); pix(1, 1);
    rst = 1; pix(1, 1); pix(1, 1); rst = 0;
    chk("mrst_valid", rif.rec_valid, 0);
    chk("mrst_len", rif.rec_len, 0);
    chk("mrst_overflow", overflow, 0);
    for (int x = 0; x < 5; x++) pix(1, 1);
    pix(0, 0);
    chk("mrst_after_valid", rif.rec_valid, 1);
    chk("mrst_after_line", rif.rec_line, 0);
    chk("mrst_after_start", rif.rec_start, 0);
    chk("mrst_after_len", rif.rec_len, 5);
    rif.rec_ready = 1;
    idle(3);

    // Random frames and consumer stalls against the model.
    rand_ready = 1;
    for (int f = 0; f < 10; f++) begin
      vsync_pulse();
      for (int l = 0, nl = $urandom_range(2, 12); l < nl; l++) begin
        int w, dens;
        w = $urandom_range(1, 24);
        dens = $urandom_range(1, 3);
        for (int x = 0; x < w; x++) pix(1, $urandom_range(0, 3) < dens);
        pix(0, 0);
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) begin
          rst = 1; tick(); tick(); rst = 0;
        end
      end
    end
    rand_ready = 0;
    rif.rec_ready = 1;
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
